gpc_acc_stage: RTL and testbench

GPC_ACC_STAGE -- requirements
Module: gpc_acc_stage

---
 rtl/gpc_acc_stage.sv | 105 ++++++++++
 tb/tb_gpc_acc_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpc_acc_stage.sv
// gpc_acc_stage: collects 4-bit gpc117_4 counts over a frame into a saturating
// sum and beat count, tracking overflow and out-of-range beats, then holds the
// frame result until downstream takes it.
module gpc_acc_stage #(
  parameter int SUM_W  = 16,
  parameter int BEAT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [3:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic [BEAT_W-1:0] out_beats,
  output logic              out_ovf,
  output logic              out_err
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  localparam logic [SUM_W-1:0] SUM_MAX = '1;

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [BEAT_W-1:0]  beats_q, beats_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;

  logic               accept;
  logic               take;
  logic               beat_sat;
  logic [SUM_W:0]     sum_ext;

  // Handshakes and saturation helpers; one extra sum bit exposes the carry out.
  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;
  assign beat_sat  = &beats_q;
  assign sum_ext   = {1'b0, sum_q} + {{(SUM_W - 3){1'b0}}, in_data};

  // Result ports are the live accumulator; they are frozen while in HOLD.
  assign out_sum   = sum_q;
  assign out_beats = beats_q;
  assign out_ovf   = ovf_q;
  assign out_err   = err_q;

  // Next-state and accumulator update for one accepted beat or one result handoff.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    beats_d = beats_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          sum_d   = sum_ext[SUM_W] ? SUM_MAX : sum_ext[SUM_W-1:0];
          beats_d = beat_sat ? beats_q : beats_q + BEAT_W'(1);
          ovf_d   = ovf_q | sum_ext[SUM_W] | beat_sat;
          err_d   = err_q | (in_data > 4'd13);
          state_d = in_last ? HOLD : ACC;
        end
      end
      HOLD: begin
        // The handoff cycle never accepts a beat; clearing here frees the next frame.
        if (take) begin
          state_d = IDLE;
          sum_d   = '0;
          beats_d = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        sum_d   = '0;
        beats_d = '0;
        ovf_d   = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  // State registers; reset drops any partial or pending frame immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      beats_q <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      beats_q <= beats_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_gpc_acc_stage.sv
// Bench for gpc_acc_stage: three instances (default widths, SUM_W=5, BEAT_W=2)
// share one stimulus stream and are checked against a frame-level model.
module tb_gpc_acc_stage;

  logic        clk, rst, in_valid, in_last, out_ready;
  logic [3:0]  in_data;

  logic        rdy0, rdy1, rdy2, val0, val1, val2;
  logic        ovf0, ovf1, ovf2, err0, err1, err2;
  logic [15:0] sum0, sum2;
  logic [4:0]  sum1;
  logic [7:0]  bts0, bts1;
  logic [1:0]  bts2;

  gpc_acc_stage #(.SUM_W(16), .BEAT_W(8)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(rdy0), .out_valid(val0), .out_ready(out_ready),
    .out_sum(sum0), .out_beats(bts0), .out_ovf(ovf0), .out_err(err0));
  gpc_acc_stage #(.SUM_W(5), .BEAT_W(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(rdy1), .out_valid(val1), .out_ready(out_ready),
    .out_sum(sum1), .out_beats(bts1), .out_ovf(ovf1), .out_err(err1));
  gpc_acc_stage #(.SUM_W(16), .BEAT_W(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(rdy2), .out_valid(val2), .out_ready(out_ready),
    .out_sum(sum2), .out_beats(bts2), .out_ovf(ovf2), .out_err(err2));

  localparam int W_S [3] = '{16, 5, 16};
  localparam int W_B [3] = '{8, 8, 2};

  int a_sum [3], a_bts [3], a_rdy [3], a_val [3], a_ovf [3], a_err [3];
  always_comb begin
    a_sum[0] = int'(sum0); a_sum[1] = int'(sum1); a_sum[2] = int'(sum2);
    a_bts[0] = int'(bts0); a_bts[1] = int'(bts1); a_bts[2] = int'(bts2);
    a_rdy[0] = int'(rdy0); a_rdy[1] = int'(rdy1); a_rdy[2] = int'(rdy2);
    a_val[0] = int'(val0); a_val[1] = int'(val1); a_val[2] = int'(val2);
    a_ovf[0] = int'(ovf0); a_ovf[1] = int'(ovf1); a_ovf[2] = int'(ovf2);
    a_err[0] = int'(err0); a_err[1] = int'(err1); a_err[2] = int'(err2);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_frames = 0;

  // Frame-level model: the beats of the current frame and whether it is being held.
  bit m_hold;
  int m_q [$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int tot, n, smax, bmax;
    bit er;
    tot = 0; er = 0; n = m_q.size();
    foreach (m_q[k]) begin
      tot += m_q[k];
      if (m_q[k] > 13) er = 1;
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d.out_valid", i), a_val[i], int'(m_hold));
      chk($sformatf("u%0d.in_ready", i), a_rdy[i], int'(!m_hold));
      if (m_hold) begin
        smax = (1 << W_S[i]) - 1;
        bmax = (1 << W_B[i]) - 1;
        chk($sformatf("u%0d.out_sum", i), a_sum[i], (tot > smax) ? smax : tot);
        chk($sformatf("u%0d.out_beats", i), a_bts[i], (n > bmax) ? bmax : n);
        chk($sformatf("u%0d.out_ovf", i), a_ovf[i], int'((tot > smax) || (n > bmax)));
        chk($sformatf("u%0d.out_err", i), a_err[i], int'(er));
      end
    end
  endtask

  bit c_v, c_l, c_r;
  int c_d;

  // Drive one cycle's inputs and check the pre-edge outputs against the model.
  task automatic begin_cycle(input bit v, input int d, input bit l, input bit r);
    in_valid = v; in_data = 4'(d); in_last = l; out_ready = r;
    c_v = v; c_d = d; c_l = l; c_r = r;
    #1;
    check_model();
  endtask

  // Apply the rules for this cycle to the model, then advance past the edge.
  task automatic end_cycle();
    if (m_hold) begin
      if (c_r) begin
        n_frames++;
        $display("frame %0d taken: sum=%0d beats=%0d ovf=%0d err=%0d",
                 n_frames, sum0, bts0, ovf0, err0);
        m_hold = 0;
        m_q.delete();
      end
    end else if (c_v) begin
      m_q.push_back(c_d);
      if (c_l) m_hold = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input bit v, input int d, input bit l, input bit r);
    begin_cycle(v, d, l, r);
    end_cycle();
  endtask

  typedef struct {
    bit v; int d; bit l; bit r;
    bit ev; bit er; int es; int eb; bit eo; bit ee;
  } vec_t;
  vec_t tbl [12];

  initial begin
    //          v  d  l  r   val rdy sum beats ovf err
    tbl[0]  = '{1, 13, 0, 1,  0, 1,  0, 0, 0, 0};
    tbl[1]  = '{1, 13, 0, 1,  0, 1,  0, 0, 0, 0};
    tbl[2]  = '{1,  7, 0, 1,  0, 1,  0, 0, 0, 0};
    tbl[3]  = '{1,  0, 1, 1,  0, 1,  0, 0, 0, 0};
    tbl[4]  = '{0,  0, 0, 1,  1, 0, 33, 4, 0, 0};
    tbl[5]  = '{0,  0, 0, 1,  0, 1,  0, 0, 0, 0};
    tbl[6]  = '{1, 15, 1, 0,  0, 1,  0, 0, 0, 0};
    tbl[7]  = '{1,  2, 1, 0,  1, 0, 15, 1, 0, 1};
    tbl[8]  = '{0,  0, 0, 1,  1, 0, 15, 1, 0, 1};
    tbl[9]  = '{1,  2, 1, 1,  0, 1,  0, 0, 0, 0};
    tbl[10] = '{0,  0, 0, 1,  1, 0,  2, 1, 0, 0};
    tbl[11] = '{0,  0, 0, 0,  0, 1,  0, 0, 0, 0};

    m_hold = 0;
    rst = 1'b1; in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
    #2;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst u%0d.out_valid", i), a_val[i], 0);
      chk($sformatf("rst u%0d.in_ready", i), a_rdy[i], 1);
      chk($sformatf("rst u%0d.out_sum", i), a_sum[i], 0);
      chk($sformatf("rst u%0d.out_beats", i), a_bts[i], 0);
      chk($sformatf("rst u%0d.out_ovf", i), a_ovf[i], 0);
      chk($sformatf("rst u%0d.out_err", i), a_err[i], 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Table: basic 4-beat frame, then error frame followed by a clean one.
    for (int t = 0; t < 12; t++) begin
      begin_cycle(tbl[t].v, tbl[t].d, tbl[t].l, tbl[t].r);
      chk($sformatf("tbl%0d out_valid", t), int'(val0), int'(tbl[t].ev));
      chk($sformatf("tbl%0d in_ready", t), int'(rdy0), int'(tbl[t].er));
      if (tbl[t].ev) begin
        chk($sformatf("tbl%0d out_sum", t), int'(sum0), tbl[t].es);
        chk($sformatf("tbl%0d out_beats", t), int'(bts0), tbl[t].eb);
        chk($sformatf("tbl%0d out_ovf", t), int'(ovf0), int'(tbl[t].eo));
        chk($sformatf("tbl%0d out_err", t), int'(err0), int'(tbl[t].ee));
      end
      end_cycle();
    end

    // Narrow sum saturates at 31.
    cycle(1, 13, 0, 0); cycle(1, 13, 0, 0); cycle(1, 13, 1, 0);
    begin_cycle(0, 0, 0, 1);
    chk("sat5 out_sum", int'(sum1), 31);
    chk("sat5 out_ovf", int'(ovf1), 1);
    end_cycle();

    // Narrow beat counter saturates at 3.
    for (int k = 0; k < 4; k++) cycle(1, 1, 0, 0);
    cycle(1, 1, 1, 0);
    begin_cycle(0, 0, 0, 1);
    chk("bsat2 out_beats", int'(bts2), 3);
    chk("bsat2 out_sum", int'(sum2), 5);
    chk("bsat2 out_ovf", int'(ovf2), 1);
    end_cycle();

    // Backpressure: held result stays put, pending beat waits for in_ready.
    cycle(1, 3, 0, 0); cycle(1, 4, 1, 0);
    for (int k = 0; k < 5; k++) begin
      begin_cycle(1, 9, 1, 0);
      chk("bp in_ready", int'(rdy0), 0);
      chk("bp out_sum", int'(sum0), 7);
      end_cycle();
    end
    begin_cycle(1, 9, 1, 1);
    chk("bp take in_ready", int'(rdy0), 0);
    end_cycle();
    begin_cycle(1, 9, 1, 0);
    chk("bp after in_ready", int'(rdy0), 1);
    end_cycle();
    begin_cycle(0, 0, 0, 1);
    chk("bp next out_sum", int'(sum0), 9);
    end_cycle();

    // Asynchronous reset in mid-frame.
    cycle(1, 5, 0, 0); cycle(1, 6, 0, 0);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("arst u%0d.out_valid", i), a_val[i], 0);
      chk($sformatf("arst u%0d.in_ready", i), a_rdy[i], 1);
      chk($sformatf("arst u%0d.out_sum", i), a_sum[i], 0);
      chk($sformatf("arst u%0d.out_beats", i), a_bts[i], 0);
    end
    #1 rst = 1'b0;
    m_hold = 0;
    m_q.delete();
    cycle(1, 6, 1, 0);
    begin_cycle(0, 0, 0, 1);
    chk("arst next out_sum", int'(sum0), 6);
    chk("arst next out_beats", int'(bts0), 1);
    end_cycle();

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      int d;
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 15)) : int'($urandom_range(0, 13));
      cycle(bit'($urandom_range(0, 3) != 0), d, bit'($urandom_range(0, 5) == 0),
            bit'($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
